// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared constants and helpers for the UART receive path
package uart_rx_pkg;

    localparam int   MIN_PRESCALE = 8;
    localparam logic IDLE_LEVEL   = 1'b1;

    // Two-of-three vote, shared with the parity and stop checks.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser with configurable reset level
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_ff1;
    logic r_ff2;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ff1 <= RESET_VAL;
            r_ff2 <= RESET_VAL;
        end else begin
            r_ff1 <= i_d;
            r_ff2 <= r_ff1;
        end
    end

    assign o_q = r_ff2;

endmodule

// File: rtl/data_sampling.sv
// rtl/data_sampling.sv - UART RX oversampling edge counter with three-sample majority vote
module data_sampling
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W   = 6,
    parameter int MIN_PRESCALE = uart_rx_pkg::MIN_PRESCALE
) (
    input  logic                  clk_based_on_prescale,
    input  logic                  syn_reset,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  sampling_enable,
    output logic [PRESCALE_W-1:0] edge_count,
    output logic                  sampled_data,
    output logic                  sampled_data_valid,
    output logic                  bit_done
);

    localparam logic [PRESCALE_W-1:0] MIN_PL = PRESCALE_W'(MIN_PRESCALE);
    localparam logic [PRESCALE_W-1:0] ONE    = PRESCALE_W'(1);
    localparam logic [PRESCALE_W-1:0] TWO    = PRESCALE_W'(2);

    logic                  w_rx_sync;
    logic                  w_en_rise;
    logic [PRESCALE_W-1:0] w_prescale_clamped;
    logic [PRESCALE_W-1:0] w_prescale_eff;
    logic [PRESCALE_W-1:0] w_mid;
    logic                  w_at_s0;
    logic                  w_at_s1;
    logic                  w_at_mid;
    logic                  w_at_last;

    logic                  r_en_d;
    logic [PRESCALE_W-1:0] r_prescale_l;
    logic [PRESCALE_W-1:0] r_edge_count;
    logic [2:0]            r_samples;
    logic                  r_sampled_data;
    logic                  r_valid;
    logic                  r_bit_done;

    sync_2ff #(
        .RESET_VAL (IDLE_LEVEL)
    ) u_sync (
        .i_clk (clk_based_on_prescale),
        .i_rst (syn_reset),
        .i_d   (rx_in),
        .o_q   (w_rx_sync)
    );

    // On the rising-enable cycle the latch has not loaded yet, so compare
    // against the freshly clamped prescale directly.
    always_comb begin
        w_en_rise          = sampling_enable & ~r_en_d;
        w_prescale_clamped = (prescale < MIN_PL) ? MIN_PL : prescale;
        w_prescale_eff     = w_en_rise ? w_prescale_clamped : r_prescale_l;
        w_mid              = w_prescale_eff >> 1;
        w_at_s0            = (r_edge_count == (w_mid - TWO));
        w_at_s1            = (r_edge_count == (w_mid - ONE));
        w_at_mid           = (r_edge_count == w_mid);
        w_at_last          = (r_edge_count == (w_prescale_eff - ONE));
    end

    always_ff @(posedge clk_based_on_prescale) begin
        if (syn_reset) begin
            r_en_d         <= 1'b0;
            r_prescale_l   <= MIN_PL;
            r_edge_count   <= '0;
            r_samples      <= 3'b111;
            r_sampled_data <= IDLE_LEVEL;
            r_valid        <= 1'b0;
            r_bit_done     <= 1'b0;
        end else begin
            r_en_d <= sampling_enable;
            if (w_en_rise) begin
                r_prescale_l <= w_prescale_clamped;
            end
            if (!sampling_enable) begin
                // Abandon any partial bit; strobes due on this edge are dropped.
                r_edge_count <= '0;
                r_samples    <= 3'b111;
                r_valid      <= 1'b0;
                r_bit_done   <= 1'b0;
            end else begin
                r_edge_count <= w_at_last ? '0 : r_edge_count + ONE;
                if (w_at_s0) begin
                    r_samples[0] <= w_rx_sync;
                end
                if (w_at_s1) begin
                    r_samples[1] <= w_rx_sync;
                end
                if (w_at_mid) begin
                    r_samples[2]   <= w_rx_sync;
                    r_sampled_data <= majority3(r_samples[0], r_samples[1], w_rx_sync);
                end
                r_valid    <= w_at_mid;
                r_bit_done <= w_at_last;
            end
        end
    end

    assign edge_count         = r_edge_count;
    assign sampled_data       = r_sampled_data;
    assign sampled_data_valid = r_valid;
    assign bit_done           = r_bit_done;

endmodule

// File: doc/data_sampling.md
Name: data_sampling

Overview:
Oversampling front end of the UART receiver. Synchronises the raw serial line and runs the per-bit edge counter. It takes three samples around the bit centre and produces a majority-voted bit with a one-cycle valid strobe. Its sampled_data / sampled_data_valid outputs feed start_check, and also the parity, stop and deserialiser stages. It is enabled per frame by the RX FSM.

Parameters:
PRESCALE_W, 6, width of the prescale input and of edge_count.
MIN_PRESCALE, 8, smallest supported oversampling ratio; smaller values are clamped to it.

Ports:
clk_based_on_prescale  input  1  oversampling clock (prescale ticks per bit)
syn_reset  input  1  synchronous, active-high reset
rx_in  input  1  raw asynchronous serial line, idle high
prescale  input  PRESCALE_W  oversampling ratio (8, 16, 32 typical; any value >= 8 legal)
sampling_enable  input  1  from the RX FSM; high for the whole frame
edge_count  output  PRESCALE_W  current oversample index within the bit, 0..prescale_l-1
sampled_data  output  1  majority-voted bit value
sampled_data_valid  output  1  one-cycle strobe; sampled_data is meaningful while it is high
bit_done  output  1  one-cycle strobe on the last edge of each bit period

Behaviour:
- Reset (syn_reset=1 at a rising clk edge): sync_ff1=sync_ff2=1, edge_count=0, sample regs=3'b111, sampled_data=1, sampled_data_valid=0, bit_done=0, prescale_l=MIN_PRESCALE. Reset overrides all other inputs.
- Synchroniser: rx_in passes through two flops and the result is rx_sync. It runs regardless of enable. Latency from rx_in to rx_sync is 2 cycles.
- Prescale latch: prescale_l is captured on the cycle sampling_enable rises (0->1). It is held for the rest of the frame. If prescale < MIN_PRESCALE, prescale_l = MIN_PRESCALE. Changes to prescale mid-frame are ignored.
- mid = prescale_l >> 1. For odd prescale_l, mid uses floor.
- Edge counter, when sampling_enable=1:
  - edge_count increments each cycle.
  - At prescale_l-1 it wraps to 0.
  - The first enabled cycle shows edge_count=0.
- Edge counter, when sampling_enable=0: edge_count=0 on the next edge.
- Sampling: rx_sync is captured into s0, s1, s2 in the cycles where edge_count == mid-2, mid-1 and mid respectively.
- Vote: sampled_data = (s0&s1)|(s0&s2)|(s1&s2).
  - Registered at the end of the edge_count==mid cycle, so it is visible while edge_count==mid+1.
  - sampled_data_valid=1 for exactly that one cycle.
  - sampled_data holds its value until the next vote.
- bit_done=1 in the cycle after the edge_count==prescale_l-1 cycle, i.e. coincident with the wrap to 0. It is a one-cycle pulse.
- Enable dropped mid-bit: on the next edge, edge_count=0, valid=0, bit_done=0 and the sample regs reset to 3'b111. A partial vote is never emitted.
- Enable re-asserted: counting restarts from 0 and prescale is latched again.
- Output rules:
  - Valid and bit_done are never asserted while enable is low, except for a strobe scheduled on the same edge that enable falls; that strobe is suppressed.
  - Valid and bit_done never coincide, since mid+1 < prescale_l for prescale_l >= 8.
- Arithmetic: all edge comparisons are unsigned PRESCALE_W-bit.

Decomposition:
- Shared package uart_rx_pkg holds:
  - MIN_PRESCALE
  - IDLE_LEVEL=1'b1
  - the majority3 function, which is reused by the parity and stop checks
- One sub-module, sync_2ff: a 2-flop synchroniser with a reset value parameter (IDLE_LEVEL).
- The counter, sample registers and vote stay in data_sampling.

Test Plan:
1. prescale=8, enable high, rx_in held 0 from 4 cycles before enable -> samples at edge 2,3,4; valid at edge_count=5 with sampled_data=0; bit_done at every wrap (period 8).
2. prescale=16, rx_in=1 except a single-cycle low that lands on the rx_sync sample at edge 7 -> vote=1 (glitch rejected); two-cycle low covering edges 6,7 -> vote=0.
3. prescale=32, alternating bits 1,0,1,1 driven every 32 cycles, aligned -> valid pulses every 32 cycles at edge 17 carrying 1,0,1,1.
4. prescale=4 -> clamped: behaviour identical to scenario 1 (wrap period 8, valid at edge 5).
5. Drop enable at edge_count=3, prescale 8 -> no valid strobe; edge_count=0 next cycle. Re-enable with prescale=16 -> new period 16, valid at edge 9.
6. Assert syn_reset at edge_count=4 mid-frame -> next edge shows all outputs at reset values; enable still high -> counting restarts at 0 the cycle after reset is released.
